// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding and the byte-lane merge helper.
package if_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_DRAIN = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_e;

    // Little-endian: byte index k lands in bits [8k+7:8k].
    function automatic logic [INST_W-1:0] byte_merge(
        input logic [INST_W-1:0] word,
        input logic [1:0]        k,
        input logic [BYTE_W-1:0] b
    );
        logic [INST_W-1:0] w;
        w = word;
        w[k*BYTE_W +: BYTE_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory port shared by the fetch stage and the memory arbiter.
interface if_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_gnt, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_gnt, output mem_rdata);
endinterface

// File: rtl/if_fetch_byte_asm.sv
// Collects returning instruction bytes into a 32-bit word and flags the fourth byte.
module if_fetch_byte_asm
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [1:0]        i_idx,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [INST_W-1:0] o_word,
    output logic              o_done
);

    logic [1:0]        r_cnt;
    logic [INST_W-1:0] r_buf;

    // o_word already includes a byte landing this cycle so completion can load it directly.
    assign o_word = i_vld ? byte_merge(r_buf, i_idx, i_byte) : r_buf;
    assign o_done = i_vld && (r_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 2'd0;
        end else if (i_vld) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_vld && !i_clr) begin
            r_buf <= o_word;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues four byte reads per instruction,
// and presents {pc, inst, valid} to decode, holding it across decode stalls.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              id_stall_i,
    if_fetch_if.master        mem,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o
);

    if_state_e         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_issue;
    logic              r_infl;
    logic [1:0]        r_infl_idx;
    logic [ADDR_W-1:0] r_out_pc;
    logic [INST_W-1:0] r_out_inst;
    logic              r_out_vld;

    logic              w_req;
    logic              w_gnt;
    logic              w_done;
    logic              w_slot_free;
    logic              w_load;
    logic [INST_W-1:0] w_word;

    // A redirect suppresses the request in its own cycle so nothing new is in flight afterwards.
    assign w_req       = !rst && !branch_flag_i && (r_state == IF_FETCH);
    assign w_gnt       = w_req && mem.mem_gnt;
    assign w_slot_free = !r_out_vld || !id_stall_i;
    assign w_load      = ((r_state == IF_DRAIN) && w_done && w_slot_free) ||
                         ((r_state == IF_HOLD) && !id_stall_i);

    assign mem.mem_req  = w_req;
    assign mem.mem_addr = rst ? ZERO_WORD : (r_pc + {30'd0, r_issue});

    assign if_pc_o    = r_out_pc;
    assign if_inst_o  = r_out_inst;
    assign if_valid_o = r_out_vld;

    if_fetch_byte_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (branch_flag_i),
        .i_vld  (r_infl),
        .i_idx  (r_infl_idx),
        .i_byte (mem.mem_rdata),
        .o_word (w_word),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IF_FETCH;
            r_pc       <= START_ADDR;
            r_issue    <= 2'd0;
            r_infl     <= 1'b0;
            r_infl_idx <= 2'd0;
            r_out_pc   <= ZERO_WORD;
            r_out_inst <= ZERO_WORD;
            r_out_vld  <= 1'b0;
        end else if (branch_flag_i) begin
            r_state   <= IF_FETCH;
            r_pc      <= branch_addr_i;
            r_issue   <= 2'd0;
            r_infl    <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_infl <= w_gnt;
            if (w_gnt) begin
                r_infl_idx <= r_issue;
            end

            case (r_state)
                IF_FETCH: begin
                    if (w_gnt) begin
                        r_issue <= r_issue + 2'd1;
                        if (r_issue == 2'd3) begin
                            r_state <= IF_DRAIN;
                        end
                    end
                end
                IF_DRAIN: begin
                    if (w_done) begin
                        r_state <= w_slot_free ? IF_FETCH : IF_HOLD;
                    end
                end
                IF_HOLD: begin
                    if (!id_stall_i) begin
                        r_state <= IF_FETCH;
                    end
                end
                default: r_state <= IF_FETCH;
            endcase

            // A load refills the slot in the same cycle decode takes the old word.
            if (w_load) begin
                r_out_inst <= w_word;
                r_out_pc   <= r_pc;
                r_out_vld  <= 1'b1;
                r_pc       <= r_pc + 32'd4;
                r_issue    <= 2'd0;
            end else if (r_out_vld && !id_stall_i) begin
                r_out_vld <= 1'b0;
            end
        end
    end

endmodule
